// File: rtl/mem_pkg.sv
// Shared types for the tagged memory arbiter: the 72-bit {tag,data} word
// and the CPU prefetch-buffer state.
package mem_pkg;

   localparam int AW_DEFAULT = 20;
   localparam int DATA_W     = 64;
   localparam int TAG_W      = 8;
   localparam int WORD_W     = DATA_W + TAG_W;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } tagged_word_t;

   typedef enum logic [1:0] {
      PF_EMPTY = 2'd0,
      PF_PEND  = 2'd1,
      PF_VALID = 2'd2
   } pf_state_t;

   function automatic tagged_word_t make_word(input logic [TAG_W-1:0]  tag,
                                              input logic [DATA_W-1:0] data);
      tagged_word_t w;
      w.tag  = tag;
      w.data = data;
      return w;
   endfunction

endpackage

// File: rtl/tagmem_arbiter.sv
// Shares one synchronous tagged RAM between a CPU address/data bus (with a
// one-word prefetch buffer at the latched address) and a lower-priority DMA port.
module tagmem_arbiter
   import mem_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   // CPU bus
   input  logic [63:0]       cpu_ad,
   input  logic [7:0]        cpu_tag,
   input  logic              cpu_astb,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   output logic [63:0]       cpu_rdata,
   output logic [7:0]        cpu_rtag,
   output logic              cpu_err,
   // DMA port
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [AW-1:0]     dma_addr,
   input  logic [63:0]       dma_wdata,
   input  logic [7:0]        dma_wtag,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [63:0]       dma_rdata,
   output logic [7:0]        dma_rtag,
   // RAM port
   output logic              ram_en,
   output logic              ram_we,
   output logic [AW-1:0]     ram_addr,
   output logic [WORD_W-1:0] ram_wdata,
   input  logic [WORD_W-1:0] ram_rdata
);

   logic          cmd_astb;
   logic          cmd_wr;
   logic          cmd_rd;
   logic          gnt;
   logic          dma_wr_go;
   logic          dma_rd_go;
   logic          pf_hit;

   tagged_word_t  cpu_wr_word;
   tagged_word_t  dma_wr_word;
   tagged_word_t  ram_word;
   tagged_word_t  rd_word;

   logic [AW-1:0] waddr_reg;
   pf_state_t     pf_st_reg;
   tagged_word_t  pf_word_reg;
   tagged_word_t  cpu_word_reg;
   logic          cpu_err_reg;
   logic          dma_rvalid_reg;

   // One CPU command per cycle: astb beats wr beats rd.
   assign cmd_astb = cpu_astb;
   assign cmd_wr   = cpu_wr & ~cpu_astb;
   assign cmd_rd   = cpu_rd & ~cpu_astb & ~cpu_wr;

   // CPU reads are served from the prefetch path, so only astb/wr own the RAM.
   assign gnt       = reset_n & dma_req & ~cpu_astb & ~cpu_wr;
   assign dma_wr_go = gnt & dma_we;
   assign dma_rd_go = gnt & ~dma_we;

   assign cpu_wr_word = make_word(cpu_tag, cpu_ad);
   assign dma_wr_word = make_word(dma_wtag, dma_wdata);
   assign ram_word    = tagged_word_t'(ram_rdata);

   assign pf_hit = dma_wr_go && (dma_addr == waddr_reg) && (pf_st_reg != PF_EMPTY);

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = dma_addr;
      ram_wdata = dma_wr_word;
      if (reset_n) begin
         if (cmd_astb) begin
            ram_en   = 1'b1;
            ram_addr = cpu_ad[AW-1:0];
         end else if (cmd_wr) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = waddr_reg;
            ram_wdata = cpu_wr_word;
         end else if (gnt) begin
            ram_en = 1'b1;
            ram_we = dma_we;
         end
      end
   end

   // While the prefetch is in flight the RAM output already holds the word.
   always_comb begin
      rd_word = '0;
      case (pf_st_reg)
         PF_PEND:  rd_word = ram_word;
         PF_VALID: rd_word = pf_word_reg;
         default:  rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         waddr_reg   <= '0;
         pf_st_reg   <= PF_EMPTY;
         pf_word_reg <= '0;
      end else begin
         if (cmd_astb) begin
            waddr_reg <= cpu_ad[AW-1:0];
            pf_st_reg <= PF_PEND;
         end else if (cmd_wr) begin
            pf_word_reg <= cpu_wr_word;
            pf_st_reg   <= PF_VALID;
         end else if (pf_hit) begin
            // A DMA write to the latched address outranks the pending capture.
            pf_word_reg <= dma_wr_word;
            pf_st_reg   <= PF_VALID;
         end else if (pf_st_reg == PF_PEND) begin
            pf_word_reg <= ram_word;
            pf_st_reg   <= PF_VALID;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_word_reg <= '0;
         cpu_err_reg  <= 1'b0;
      end else if (cmd_rd) begin
         cpu_word_reg <= rd_word;
         if (pf_st_reg == PF_EMPTY) begin
            cpu_err_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dma_rvalid_reg <= 1'b0;
      end else begin
         dma_rvalid_reg <= dma_rd_go;
      end
   end

   assign cpu_rdata  = cpu_word_reg.data;
   assign cpu_rtag   = cpu_word_reg.tag;
   assign cpu_err    = cpu_err_reg;
   assign dma_gnt    = gnt;
   assign dma_rvalid = dma_rvalid_reg;
   assign dma_rdata  = ram_word.data;
   assign dma_rtag   = ram_word.tag;

endmodule

// File: tb/tb_tagmem_arbiter.sv
// Self-checking bench for tagmem_arbiter: directed scenarios followed by random
// traffic, checked against a memory-level reference model.
module tb_tagmem_arbiter;
   import mem_pkg::*;

   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [63:0]   cpu_ad;
   logic [7:0]    cpu_tag;
   logic          cpu_astb, cpu_rd, cpu_wr;
   logic [63:0]   cpu_rdata;
   logic [7:0]    cpu_rtag;
   logic          cpu_err;
   logic          dma_req, dma_we;
   logic [AW-1:0] dma_addr;
   logic [63:0]   dma_wdata;
   logic [7:0]    dma_wtag;
   logic          dma_gnt, dma_rvalid;
   logic [63:0]   dma_rdata;
   logic [7:0]    dma_rtag;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [71:0]   ram_wdata;
   logic [71:0]   ram_rdata;

   always #5 clk = ~clk;

   tagmem_arbiter #(.AW(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_ad     (cpu_ad),
      .cpu_tag    (cpu_tag),
      .cpu_astb   (cpu_astb),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_rdata  (cpu_rdata),
      .cpu_rtag   (cpu_rtag),
      .cpu_err    (cpu_err),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_wtag   (dma_wtag),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .dma_rtag   (dma_rtag),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   function automatic logic [71:0] init_word(input int a);
      return {8'(a ^ 8'h5A), 32'hC0DE_0000, 32'(a * 7 + 1)};
   endfunction

   // Synchronous RAM; preload fills it with init_word() before traffic starts.
   logic        preload;
   logic [71:0] ram_mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
      end else if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   // Reference model: the CPU sees the memory word at the last latched address.
   logic [71:0]   m_mem [0:DEPTH-1];
   logic [AW-1:0] m_waddr;
   bit            m_have;
   bit            m_err;
   logic [71:0]   m_cpu;
   bit            m_rv;
   logic [71:0]   m_rv_word;
   bit            last_gnt;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_waddr = '0;
      m_have  = 1'b0;
      m_err   = 1'b0;
      m_cpu   = '0;
      m_rv    = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_rdata"},  72'(cpu_rdata), 72'd0);
      check({tag, "_rtag"},   72'(cpu_rtag), 72'd0);
      check({tag, "_err"},    72'(cpu_err), 72'd0);
      check({tag, "_rvalid"}, 72'(dma_rvalid), 72'd0);
      check({tag, "_gnt"},    72'(dma_gnt), 72'd0);
      check({tag, "_ram_en"}, 72'(ram_en), 72'd0);
      check({tag, "_ram_we"}, 72'(ram_we), 72'd0);
   endtask

   // One clock of traffic, entered and left at posedge+1.
   task automatic cycle(input bit astb, input bit wr, input bit rd,
                        input logic [63:0] ad, input logic [7:0] tag,
                        input bit dreq, input bit dwe, input logic [AW-1:0] daddr,
                        input logic [63:0] dwd, input logic [7:0] dwt);
      bit          exp_gnt;
      logic [71:0] pre_word;
      cpu_astb = astb; cpu_wr = wr; cpu_rd = rd; cpu_ad = ad; cpu_tag = tag;
      dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_wtag = dwt;
      #3;
      exp_gnt  = dreq && !astb && !wr;
      last_gnt = dma_gnt;
      check("dma_gnt", 72'(dma_gnt), 72'(exp_gnt));
      check("ram_en", 72'(ram_en), 72'(astb || wr || exp_gnt));
      check("ram_we", 72'(ram_we), 72'((wr && !astb) || (exp_gnt && dwe)));
      if (astb) check("ram_addr", 72'(ram_addr), 72'(ad[AW-1:0]));
      $display("cyc t=%0t astb=%0b wr=%0b rd=%0b ad=%h dreq=%0b dwe=%0b daddr=%h gnt=%0b",
               $time, astb, wr, rd, ad, dreq, dwe, daddr, dma_gnt);

      pre_word = m_have ? m_mem[m_waddr] : 72'd0;
      m_rv = exp_gnt && !dwe;
      if (m_rv) m_rv_word = m_mem[daddr];
      if (astb) begin
         m_waddr = ad[AW-1:0];
         m_have  = 1'b1;
      end else if (wr) begin
         m_mem[m_waddr] = {tag, ad};
         m_have = 1'b1;
      end else if (rd) begin
         m_cpu = pre_word;
         if (!m_have) m_err = 1'b1;
      end
      if (exp_gnt && dwe) m_mem[daddr] = {dwt, dwd};

      @(posedge clk);
      #1;
      check("cpu_rdata", 72'(cpu_rdata), 72'(m_cpu[63:0]));
      check("cpu_rtag", 72'(cpu_rtag), 72'(m_cpu[71:64]));
      check("cpu_err", 72'(cpu_err), 72'(m_err));
      check("dma_rvalid", 72'(dma_rvalid), 72'(m_rv));
      if (m_rv) check("dma_rword", {dma_rtag, dma_rdata}, m_rv_word);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 64'd0, 8'd0, 0, 0, '0, 64'd0, 8'd0);
   endtask

   task automatic cpu_astb_at(input logic [63:0] ad);
      cycle(1, 0, 0, ad, 8'd0, 0, 0, '0, 64'd0, 8'd0);
   endtask

   task automatic cpu_read();
      cycle(0, 0, 1, 64'd0, 8'd0, 0, 0, '0, 64'd0, 8'd0);
   endtask

   task automatic dma_read(input logic [AW-1:0] a);
      cycle(0, 0, 0, 64'd0, 8'd0, 1, 0, a, 64'd0, 8'd0);
   endtask

   task automatic do_reset();
      cpu_astb = 0; cpu_wr = 0; cpu_rd = 0; dma_req = 0; dma_we = 0;
      reset_n = 1'b0;
      #1;
      check_zero_outputs("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [63:0]   rad;
      logic [AW-1:0] rda;

      for (int i = 0; i < DEPTH; i++) m_mem[i] = init_word(i);
      model_reset();
      m_rv_word = '0;
      reset_n = 1'b0; preload = 1'b1;
      cpu_ad = '0; cpu_tag = '0; cpu_astb = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b1;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = '0; dma_wdata = '0; dma_wtag = '0;
      @(posedge clk);
      #1;
      preload = 1'b0;
      check_zero_outputs("por");
      cpu_astb = 1'b0; cpu_wr = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Latch, write, re-latch, read back.
      cpu_astb_at(64'h0000_0000_0001_0010 | 64'hFFFF_0000_0000_0000);
      cycle(0, 1, 0, 64'h1234, 8'h5, 0, 0, '0, 64'd0, 8'd0);
      cpu_astb_at(64'h10);
      cpu_read();
      check("req028_data", 72'(cpu_rdata), 72'h1234);
      check("req028_tag", 72'(cpu_rtag), 72'h5);
      check("req028_err", 72'(cpu_err), 72'd0);

      // Read with nothing latched: zero data and a sticky error.
      do_reset();
      cpu_read();
      check("req029_data", 72'(cpu_rdata), 72'd0);
      check("req029_err", 72'(cpu_err), 72'd1);
      cpu_astb_at(64'h10);
      cpu_read();
      check("req029_valid_data", 72'(cpu_rdata), 72'h1234);
      check("req029_err_held", 72'(cpu_err), 72'd1);

      // DMA write blocked by astb, granted the next cycle.
      cycle(1, 0, 0, 64'h40, 8'd0, 1, 1, 12'h033, 64'hBEEF, 8'h77);
      check("req030_gnt_blocked", 72'(last_gnt), 72'd0);
      cycle(0, 0, 0, 64'd0, 8'd0, 1, 1, 12'h033, 64'hBEEF, 8'h77);
      check("req030_gnt_next", 72'(last_gnt), 72'd1);
      dma_read(12'h033);
      check("req030_ram_word", {dma_rtag, dma_rdata}, {8'h77, 64'hBEEF});

      // DMA write to the address being prefetched overrides the capture.
      cycle(1, 0, 0, 64'h20, 8'd0, 1, 1, 12'h020, 64'hAA, 8'h1);
      cycle(0, 0, 0, 64'd0, 8'd0, 1, 1, 12'h020, 64'hAA, 8'h1);
      cpu_read();
      check("req031_data", 72'(cpu_rdata), 72'hAA);
      check("req031_tag", 72'(cpu_rtag), 72'h1);

      // Back-to-back DMA reads.
      dma_read(12'd0);
      check("req032_rd0", {dma_rtag, dma_rdata}, init_word(0));
      dma_read(12'd1);
      check("req032_rd1", {dma_rtag, dma_rdata}, init_word(1));
      dma_read(12'd2);
      check("req032_rd2", {dma_rtag, dma_rdata}, init_word(2));
      idle();
      check("req032_rvalid_end", 72'(dma_rvalid), 72'd0);

      // Reset pulse while a DMA read is granted.
      cpu_astb = 0; cpu_wr = 0; cpu_rd = 0;
      dma_req = 1; dma_we = 0; dma_addr = 12'd5;
      #3;
      check("req033_gnt_before", 72'(dma_gnt), 72'd1);
      reset_n = 1'b0;
      #1;
      check_zero_outputs("req033_in_reset");
      @(posedge clk);
      #1;
      check_zero_outputs("req033_after_edge");
      reset_n = 1'b1;
      model_reset();
      dma_read(12'd3);
      check("req033_resume_rvalid", 72'(dma_rvalid), 72'd1);
      check("req033_resume_word", {dma_rtag, dma_rdata}, init_word(3));

      // Random traffic over a small address window so hits are frequent.
      for (int n = 0; n < 400; n++) begin
         rad = {$urandom, $urandom};
         rad[AW-1:0] = AW'($urandom_range(0, 7));
         rda = AW'($urandom_range(0, 7));
         cycle(($urandom % 5) == 0, ($urandom % 5) == 0, ($urandom % 5) < 2,
               rad, 8'($urandom),
               ($urandom % 2) == 0, ($urandom % 2) == 0, rda,
               {$urandom, $urandom}, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
